// File: rtl/csr_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// csr_access_ctrl_if
//   Bundles the pipeline request channel, the trap-unit write channel, the CSR
//   storage array port and the busy status of csr_access_ctrl.
//   Optional macro: CSR_RO_PROTECT_EN adds pl_illegal.
//
//   Modports:
//     slave  - the access controller (accepts requests, drives the array)
//     master - the surroundings (pipeline, trap unit, storage array)
//
//   Signals:
//     pl_req/pl_op/pl_addr/pl_src/pl_src_is_x0 -> pipeline CSR request
//     pl_ack/pl_rdata (/pl_illegal)           <- pipeline completion
//     trap_req/trap_addr/trap_wdata           -> trap-unit write request
//     trap_ack                                <- trap completion
//     csr_rdAddr/csr_write/csr_wrAddr/csr_wrVal <- array control
//     csr_rdVal                               -> array read data (forwarded)
//     busy                                    <- controller not idle
// -----------------------------------------------------------------------------
interface csr_access_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              pl_req;
  logic [1:0]        pl_op;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_src;
  logic              pl_src_is_x0;
  logic              pl_ack;
  logic [DATA_W-1:0] pl_rdata;
`ifdef CSR_RO_PROTECT_EN
  logic              pl_illegal;
`endif
  logic              trap_req;
  logic [ADDR_W-1:0] trap_addr;
  logic [DATA_W-1:0] trap_wdata;
  logic              trap_ack;
  logic [ADDR_W-1:0] csr_rdAddr;
  logic [DATA_W-1:0] csr_rdVal;
  logic              csr_write;
  logic [ADDR_W-1:0] csr_wrAddr;
  logic [DATA_W-1:0] csr_wrVal;
  logic              busy;

  modport slave (
    input  pl_req, pl_op, pl_addr, pl_src, pl_src_is_x0,
    input  trap_req, trap_addr, trap_wdata,
    input  csr_rdVal,
    output pl_ack, pl_rdata,
`ifdef CSR_RO_PROTECT_EN
    output pl_illegal,
`endif
    output trap_ack,
    output csr_rdAddr, csr_write, csr_wrAddr, csr_wrVal,
    output busy
  );

  modport master (
    output pl_req, pl_op, pl_addr, pl_src, pl_src_is_x0,
    output trap_req, trap_addr, trap_wdata,
    output csr_rdVal,
    input  pl_ack, pl_rdata,
`ifdef CSR_RO_PROTECT_EN
    input  pl_illegal,
`endif
    input  trap_ack,
    input  csr_rdAddr, csr_write, csr_wrAddr, csr_wrVal,
    input  busy
  );
endinterface

// File: rtl/csr_access_ctrl.sv
// -----------------------------------------------------------------------------
// csr_access_ctrl
//   Sequences all accesses to the single-read/single-write CSR storage array.
//   Pipeline CSR instructions become a read (RD) followed by a conditional
//   write (WR); trap-unit writes (mepc/mcause/mtval) go straight to TWR.
//   Arbitration happens only in IDLE, trap before pipeline; an operation in
//   flight is never pre-empted.
//   Optional macro: CSR_RO_PROTECT_EN suppresses pipeline writes to the
//   read-only CSR space (addr[11:10]==2'b11) and flags pl_illegal instead.
//
//   Ports:
//     clk    - core clock
//     reset  - synchronous, active-high
//     bus    - csr_access_ctrl_if.slave (pipeline, trap and array signals)
//
//   State | meaning
//   IDLE  | waiting; arbitrate trap_req over pl_req
//   RD    | csr_rdAddr presents latched address, old value captured
//   WR    | read-modify-write result written, pl_ack pulsed
//   TWR   | latched trap data written, trap_ack pulsed
// -----------------------------------------------------------------------------
module csr_access_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  csr_access_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, TWR} state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  state_t            state;
  state_t            nextState;

  // Address and source/data registers are shared between pipeline and trap
  // requests: only one of them is ever in flight.
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] srcQ;
  logic [1:0]        opQ;
  logic              srcIsX0Q;
  logic [DATA_W-1:0] oldQ;
  logic [DATA_W-1:0] rdataQ;

  logic [DATA_W-1:0] newVal;
  logic              wantWrite;
  logic              roBlock;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.trap_req) begin
          nextState = TWR;
        end else if (bus.pl_req) begin
          nextState = RD;
        end
      end
      RD:      nextState = WR;
      WR:      nextState = IDLE;
      TWR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request latching and old-value capture
  always_ff @(posedge clk) begin
    if (reset) begin
      addrQ    <= '0;
      srcQ     <= '0;
      opQ      <= '0;
      srcIsX0Q <= 1'b0;
      oldQ     <= '0;
      rdataQ   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.trap_req) begin
            addrQ <= bus.trap_addr;
            srcQ  <= bus.trap_wdata;
          end else if (bus.pl_req) begin
            addrQ    <= bus.pl_addr;
            srcQ     <= bus.pl_src;
            opQ      <= bus.pl_op;
            srcIsX0Q <= bus.pl_src_is_x0;
          end
        end
        RD:      oldQ   <= bus.csr_rdVal;
        WR:      rdataQ <= oldQ;   // keeps pl_rdata stable after the ack
        default: ;
      endcase
    end
  end

  // Read-modify-write datapath
  always_comb begin
    newVal    = srcQ;
    wantWrite = 1'b0;
    case (opQ)
      OP_RW: begin
        newVal    = srcQ;
        wantWrite = 1'b1;               // RW writes even for x0
      end
      OP_RS: begin
        newVal    = oldQ | srcQ;
        wantWrite = ~srcIsX0Q;
      end
      OP_RC: begin
        newVal    = oldQ & ~srcQ;
        wantWrite = ~srcIsX0Q;
      end
      default: begin
        newVal    = oldQ;
        wantWrite = 1'b0;
      end
    endcase
  end

`ifdef CSR_RO_PROTECT_EN
  // Top two address bits both set marks the read-only CSR space.
  assign roBlock = wantWrite && (addrQ[ADDR_W-1 -: 2] == 2'b11);
`else
  assign roBlock = 1'b0;
`endif

  // Outputs. Strobes are masked by reset so that a reset landing on WR or
  // TWR aborts the write and the ack in that very cycle.
  always_comb begin
    bus.csr_write = 1'b0;
    bus.pl_ack    = 1'b0;
    bus.trap_ack  = 1'b0;
    bus.csr_wrVal = srcQ;
    bus.pl_rdata  = rdataQ;
`ifdef CSR_RO_PROTECT_EN
    bus.pl_illegal = 1'b0;
`endif
    case (state)
      WR: begin
        bus.csr_write = wantWrite && !roBlock && !reset;
        bus.pl_ack    = !reset;
        bus.csr_wrVal = newVal;
        bus.pl_rdata  = oldQ;
`ifdef CSR_RO_PROTECT_EN
        bus.pl_illegal = roBlock && !reset;
`endif
      end
      TWR: begin
        bus.csr_write = !reset;
        bus.trap_ack  = !reset;
        bus.csr_wrVal = srcQ;
      end
      default: ;
    endcase
  end

  assign bus.csr_rdAddr = addrQ;
  assign bus.csr_wrAddr = addrQ;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_csr_access_ctrl.sv
`timescale 1ns/1ps
module tb_csr_access_ctrl;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
`ifdef CSR_RO_PROTECT_EN
  localparam bit RO_PROT = 1'b1;
`else
  localparam bit RO_PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  csr_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  csr_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // CSR storage array with write forwarding and a backdoor preload port
  logic [DATA_W-1:0] csrMem [0:4095];
  logic              loadEn = 1'b0;
  logic [11:0]       loadAddr = '0;
  logic [31:0]       loadData = '0;
  always @(posedge clk) begin
    if (bus.csr_write) csrMem[bus.csr_wrAddr] <= bus.csr_wrVal;
    else if (loadEn)   csrMem[loadAddr] <= loadData;
  end
  assign bus.csr_rdVal = (bus.csr_write && bus.csr_wrAddr == bus.csr_rdAddr)
                         ? bus.csr_wrVal : csrMem[bus.csr_rdAddr];

  int wrCount = 0;
  int plAckCount = 0;
  always @(posedge clk) begin
    if (bus.csr_write) wrCount <= wrCount + 1;
    if (bus.pl_ack)    plAckCount <= plAckCount + 1;
  end

  // Reference model: expected CSR contents
  logic [31:0] refMem [0:4095];
  logic [11:0] addrSet [0:6];
  int checks = 0;
  int errors = 0;

  function automatic void refPl(input logic [1:0] op, input logic [11:0] addr,
                                input logic [31:0] src, input bit x0,
                                input logic [31:0] old, output bit doWr,
                                output logic [31:0] nv, output bit ill);
    doWr = 1'b0; nv = old; ill = 1'b0;
    case (op)
      2'b01: begin doWr = 1'b1; nv = src; end
      2'b10: if (!x0) begin doWr = 1'b1; nv = old | src; end
      2'b11: if (!x0) begin doWr = 1'b1; nv = old & ~src; end
      default: ;
    endcase
    if (RO_PROT && doWr && addr[11:10] == 2'b11) begin
      doWr = 1'b0; nv = old; ill = 1'b1;
    end
  endfunction

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    loadEn = 1'b1; loadAddr = a; loadData = v;
    @(negedge clk);
    loadEn = 1'b0;
    refMem[a] = v;
  endtask

  task automatic plTxn(input string name, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] src, input bit x0);
    logic [31:0] old, nv;
    bit doWr, ill, seen;
    int k, wr0;
    old = refMem[addr];
    refPl(op, addr, src, x0, old, doWr, nv, ill);
    @(negedge clk);
    bus.pl_req = 1'b1; bus.pl_op = op; bus.pl_addr = addr;
    bus.pl_src = src; bus.pl_src_is_x0 = x0;
    wr0 = wrCount; k = 0; seen = 1'b0;
    while (k < 10 && !seen) begin
      @(posedge clk); @(negedge clk); k++;
      if (k == 1) begin
        checks++;
        if (bus.csr_rdAddr !== addr) begin
          errors++; $display("FAIL %s rdAddr: got %h expected %h", name, bus.csr_rdAddr, addr);
        end
      end
      if (bus.pl_ack === 1'b1) seen = 1'b1;
    end
    bus.pl_req = 1'b0;
    checks++;
    if (!seen || k != 2) begin
      errors++; $display("FAIL %s latency: got %0d cycles (ack seen %0d) expected 2", name, k, seen);
    end
    checks++;
    if (bus.pl_rdata !== old) begin
      errors++; $display("FAIL %s rdata: got %h expected %h", name, bus.pl_rdata, old);
    end
`ifdef CSR_RO_PROTECT_EN
    checks++;
    if (bus.pl_illegal !== ill) begin
      errors++; $display("FAIL %s illegal: got %b expected %b", name, bus.pl_illegal, ill);
    end
`endif
    if (doWr) refMem[addr] = nv;
    @(posedge clk); @(negedge clk);
    checks++;
    if (wrCount - wr0 != int'(doWr)) begin
      errors++; $display("FAIL %s writes: got %0d expected %0d", name, wrCount - wr0, int'(doWr));
    end
    checks++;
    if (csrMem[addr] !== refMem[addr]) begin
      errors++; $display("FAIL %s array[%h]: got %h expected %h", name, addr, csrMem[addr], refMem[addr]);
    end
    checks++;
    if (bus.pl_rdata !== old || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s hold: rdata %h busy %b expected %h busy 0", name, bus.pl_rdata, bus.busy, old);
    end
  endtask

  task automatic trapTxn(input string name, input logic [11:0] addr, input logic [31:0] data);
    int k;
    bit seen;
    @(negedge clk);
    bus.trap_req = 1'b1; bus.trap_addr = addr; bus.trap_wdata = data;
    k = 0; seen = 1'b0;
    while (k < 10 && !seen) begin
      @(posedge clk); @(negedge clk); k++;
      if (bus.trap_ack === 1'b1) seen = 1'b1;
    end
    bus.trap_req = 1'b0;
    refMem[addr] = data;
    checks++;
    if (!seen || k != 1) begin
      errors++; $display("FAIL %s trap latency: got %0d (ack seen %0d) expected 1", name, k, seen);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (csrMem[addr] !== data) begin
      errors++; $display("FAIL %s trap array[%h]: got %h expected %h", name, addr, csrMem[addr], data);
    end
  endtask

  task automatic test_reset();
    bus.pl_req = 1'b0; bus.pl_op = 2'b00; bus.pl_addr = '0; bus.pl_src = '0;
    bus.pl_src_is_x0 = 1'b0; bus.trap_req = 1'b0; bus.trap_addr = '0; bus.trap_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.pl_ack, bus.trap_ack, bus.csr_write} !== 4'b0000) begin
      errors++; $display("FAIL reset strobes: got busy/plAck/trapAck/write=%b expected 0000",
                         {bus.busy, bus.pl_ack, bus.trap_ack, bus.csr_write});
    end
    checks++;
    if (bus.pl_rdata !== 32'h0 || bus.csr_wrVal !== 32'h0) begin
      errors++; $display("FAIL reset data: got rdata %h wrVal %h expected 0", bus.pl_rdata, bus.csr_wrVal);
    end
    checks++;
    if (bus.csr_rdAddr !== 12'h0 || bus.csr_wrAddr !== 12'h0) begin
      errors++; $display("FAIL reset addr: got rd %h wr %h expected 0", bus.csr_rdAddr, bus.csr_wrAddr);
    end
`ifdef CSR_RO_PROTECT_EN
    checks++;
    if (bus.pl_illegal !== 1'b0) begin
      errors++; $display("FAIL reset illegal: got %b expected 0", bus.pl_illegal);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_directed();
    preload(12'h340, 32'h12345678);
    plTxn("rw_basic", 2'b01, 12'h340, 32'hDEADBEEF, 1'b0);
    preload(12'h300, 32'h00000008);
    plTxn("rs_set", 2'b10, 12'h300, 32'h000000F0, 1'b0);
    plTxn("rc_clear", 2'b11, 12'h300, 32'h00000008, 1'b0);
    plTxn("rs_x0", 2'b10, 12'h300, 32'h0, 1'b1);
    plTxn("rc_x0", 2'b11, 12'h300, 32'h0, 1'b1);
    plTxn("probe", 2'b00, 12'h300, 32'h5A5A5A5A, 1'b0);
    plTxn("rw_zero", 2'b01, 12'h300, 32'h0, 1'b1);
  endtask

  task automatic test_ro_space();
    preload(12'hF14, 32'h00000003);
    plTxn("ro_rw", 2'b01, 12'hF14, 32'hCAFEF00D, 1'b0);
    plTxn("ro_rs_x0", 2'b10, 12'hF14, 32'h0, 1'b1);
    trapTxn("ro_trap", 12'hF14, 32'h0BADF00D);
  endtask

  task automatic test_arbitration(input string name, input int plStart, input int trapStart,
                                  input int expPlK, input int expTrapK, input logic [1:0] op,
                                  input logic [11:0] pAddr, input logic [31:0] src,
                                  input logic [11:0] tAddr, input logic [31:0] tData);
    logic [31:0] old, nv, gotRdata;
    bit doWr, ill;
    int plK, trapK;
    if (expTrapK < expPlK) refMem[tAddr] = tData;
    old = refMem[pAddr];
    refPl(op, pAddr, src, 1'b0, old, doWr, nv, ill);
    if (doWr) refMem[pAddr] = nv;
    if (expTrapK > expPlK) refMem[tAddr] = tData;
    plK = -1; trapK = -1; gotRdata = '0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      if (bus.pl_ack === 1'b1 && plK < 0) begin
        plK = k; gotRdata = bus.pl_rdata; bus.pl_req = 1'b0;
      end
      if (bus.trap_ack === 1'b1 && trapK < 0) begin
        trapK = k; bus.trap_req = 1'b0;
      end
      if (k == plStart) begin
        bus.pl_req = 1'b1; bus.pl_op = op; bus.pl_addr = pAddr;
        bus.pl_src = src; bus.pl_src_is_x0 = 1'b0;
      end
      if (k == trapStart) begin
        bus.trap_req = 1'b1; bus.trap_addr = tAddr; bus.trap_wdata = tData;
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (trapK != expTrapK) begin
      errors++; $display("FAIL %s trap_ack cycle: got %0d expected %0d", name, trapK, expTrapK);
    end
    checks++;
    if (plK != expPlK) begin
      errors++; $display("FAIL %s pl_ack cycle: got %0d expected %0d", name, plK, expPlK);
    end
    checks++;
    if (gotRdata !== old) begin
      errors++; $display("FAIL %s rdata: got %h expected %h", name, gotRdata, old);
    end
    checks++;
    if (csrMem[pAddr] !== refMem[pAddr] || csrMem[tAddr] !== refMem[tAddr]) begin
      errors++; $display("FAIL %s array: got %h/%h expected %h/%h", name,
                         csrMem[pAddr], csrMem[tAddr], refMem[pAddr], refMem[tAddr]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] src;
    int wr0, ack0, k;
    bit seen;
    src = $urandom;
    preload(12'h305, 32'h00001000);
    @(negedge clk);
    bus.pl_req = 1'b1; bus.pl_op = 2'b01; bus.pl_addr = 12'h305;
    bus.pl_src = src; bus.pl_src_is_x0 = 1'b0;
    wr0 = wrCount; ack0 = plAckCount;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.csr_write !== 1'b0 || bus.pl_ack !== 1'b0) begin
      errors++; $display("FAIL rst_mid strobes: got write %b ack %b expected 0 0", bus.csr_write, bus.pl_ack);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || wrCount != wr0 || plAckCount != ack0) begin
      errors++; $display("FAIL rst_mid abort: busy %b writes %0d acks %0d expected 0 0 0",
                         bus.busy, wrCount - wr0, plAckCount - ack0);
    end
    checks++;
    if (csrMem[12'h305] !== 32'h00001000) begin
      errors++; $display("FAIL rst_mid array: got %h expected %h", csrMem[12'h305], 32'h00001000);
    end
    reset = 1'b0;
    k = 0; seen = 1'b0;
    while (k < 10 && !seen) begin
      @(posedge clk); @(negedge clk); k++;
      if (bus.pl_ack === 1'b1) seen = 1'b1;
    end
    bus.pl_req = 1'b0;
    checks++;
    if (!seen || k != 2 || bus.pl_rdata !== 32'h00001000) begin
      errors++; $display("FAIL rst_mid reserve: latency %0d seen %0d rdata %h expected 2 1 %h",
                         k, seen, bus.pl_rdata, 32'h00001000);
    end
    refMem[12'h305] = src;
    @(posedge clk); @(negedge clk);
    checks++;
    if (csrMem[12'h305] !== src) begin
      errors++; $display("FAIL rst_mid reserve array: got %h expected %h", csrMem[12'h305], src);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [0:3];
    logic [31:0] srcs [0:3];
    logic [31:0] olds [0:3];
    logic [31:0] nv;
    bit doWr, ill;
    int idx;
    for (int i = 0; i < 4; i++) begin
      ops[i] = 2'($urandom_range(1, 3));
      srcs[i] = $urandom;
      olds[i] = refMem[12'h300];
      refPl(ops[i], 12'h300, srcs[i], 1'b0, olds[i], doWr, nv, ill);
      if (doWr) refMem[12'h300] = nv;
    end
    @(negedge clk);
    bus.pl_req = 1'b1; bus.pl_op = ops[0]; bus.pl_addr = 12'h300;
    bus.pl_src = srcs[0]; bus.pl_src_is_x0 = 1'b0;
    idx = 0;
    for (int k = 1; k <= 30 && idx < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.pl_ack === 1'b1) begin
        checks++;
        if (k != 3 * idx + 2 || bus.pl_rdata !== olds[idx]) begin
          errors++; $display("FAIL b2b op%0d: cycle %0d rdata %h expected cycle %0d rdata %h",
                             idx, k, bus.pl_rdata, 3 * idx + 2, olds[idx]);
        end
        idx++;
        if (idx < 4) begin
          bus.pl_op = ops[idx]; bus.pl_src = srcs[idx];
        end else begin
          bus.pl_req = 1'b0;
        end
      end
    end
    bus.pl_req = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (idx != 4 || csrMem[12'h300] !== refMem[12'h300]) begin
      errors++; $display("FAIL b2b final: acks %0d array %h expected 4 %h", idx, csrMem[12'h300], refMem[12'h300]);
    end
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [31:0] s;
    logic [1:0]  op;
    bit x0;
    for (int i = 0; i < 30; i++) begin
      a = addrSet[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) begin
        trapTxn("rand_trap", a, $urandom);
      end else begin
        op = 2'($urandom_range(0, 3));
        x0 = ($urandom_range(0, 3) == 0);
        s  = x0 ? 32'h0 : $urandom;
        plTxn("rand_pl", op, a, s, x0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    addrSet[0] = 12'h300; addrSet[1] = 12'h305; addrSet[2] = 12'h340;
    addrSet[3] = 12'h341; addrSet[4] = 12'h342; addrSet[5] = 12'hF14;
    addrSet[6] = 12'hC00;
    test_reset();
    for (int i = 0; i < 7; i++) preload(addrSet[i], $urandom);
    test_directed();
    test_ro_space();
    test_arbitration("arb_same_cycle", 0, 0, 4, 1, 2'b10, 12'h341, 32'h00000001,
                     12'h341, 32'h80000004);
    test_arbitration("arb_trap_in_rd", 0, 1, 2, 4, 2'b01, 12'h342, $urandom,
                     12'h342, $urandom);
    test_arbitration("arb_trap_in_wr", 0, 2, 2, 4, 2'b11, 12'h300, $urandom,
                     12'h341, $urandom);
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
